ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the EX stage of the 3-stage core. It sits directly downstream of the ID/EX pipeline register and consumes its delayed operands, destination address and write enable, plus the decoded M-extension funct3. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations, or in a fast path for division special cases. While it works, it stalls the ID/EX register, then presents one writeback beat.

---
 rtl/ex_muldiv_pkg.sv | 34 +++
 rtl/ex_muldiv.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// operand width, M-extension funct3 codes, FSM state encoding and
// operand-signedness decode helpers.
package ex_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ACC_W = 2 * XLEN;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rs1 is signed for everything except the fully unsigned forms
  function automatic logic op1_is_signed(input logic [2:0] f3);
    return !((f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU));
  endfunction

  // rs2 is signed only for the fully signed forms (MULHSU treats it unsigned)
  function automatic logic op2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. Works on operand magnitudes for
// 32 cycles (shift-add multiply or restoring divide), applies the result
// sign on the final iteration and presents a single writeback beat.
// Division by zero and signed overflow bypass the iteration entirely.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr,
  input  logic            rd_wen,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_wen
);

  state_e             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [2:0]         f3_q, f3_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic               rd_wen_q, rd_wen_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic               wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [4:0]         wb_rd_addr_q, wb_rd_addr_d;
  logic               wb_rd_wen_q, wb_rd_wen_d;

  logic               a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [XLEN:0]      mul_sum, div_diff;
  logic [ACC_W-1:0]   mul_next, div_next, acc_step, prod;
  logic [XLEN-1:0]    calc_result;

  function automatic logic [XLEN-1:0] neg_xlen(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [ACC_W-1:0] neg_acc(input logic n, input logic [ACC_W-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign a_neg    = op1_is_signed(funct3) & op1[XLEN-1];
  assign b_neg    = op2_is_signed(funct3) & op2[XLEN-1];
  assign a_mag    = neg_xlen(a_neg, op1);
  assign b_mag    = neg_xlen(b_neg, op2);
  assign is_div   = funct3[2];
  assign div_zero = is_div & (op2 == '0);
  assign div_ovf  = is_div & ~funct3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);

  // One iteration of multiply/divide plus final signed result selection
  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole pair right.
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: shift remainder:quotient left, trial-subtract the divisor;
    // the borrow bit decides whether to keep the difference.
    div_diff = acc_q[ACC_W-1:XLEN-1] - {1'b0, opb_q};
    div_next = div_diff[XLEN] ? {acc_q[ACC_W-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step = f3_q[2] ? div_next : mul_next;
    prod     = neg_acc(neg_q, mul_next);
    case (f3_q)
      F3_MUL:                        calc_result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  calc_result = prod[ACC_W-1:XLEN];
      F3_DIV, F3_DIVU:               calc_result = neg_xlen(neg_q, div_next[XLEN-1:0]);
      default:                       calc_result = neg_xlen(neg_q, div_next[ACC_W-1:XLEN]);
    endcase
  end

  // Next-state and writeback decision for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    f3_d         = f3_q;
    rd_addr_d    = rd_addr_q;
    rd_wen_d     = rd_wen_q;
    neg_d        = neg_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_wen_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          f3_d      = funct3;
          rd_addr_d = rd_addr;
          rd_wen_d  = rd_wen;
          opb_d     = b_mag;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          count_d   = '0;
          // Remainder takes the dividend sign; quotient/product the XOR
          neg_d     = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            state_d      = ST_DONE;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_addr;
            wb_rd_wen_d  = rd_wen;
            if (div_zero) wb_data_d = funct3[1] ? op1 : '1;
            else          wb_data_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d      = ST_DONE;
          count_d      = '0;
          wb_valid_d   = 1'b1;
          wb_data_d    = calc_result;
          wb_rd_addr_d = rd_addr_q;
          wb_rd_wen_d  = rd_wen_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush cancels whatever is in progress and wins over a new start
    if (flush) begin
      state_d      = ST_IDLE;
      count_d      = '0;
      wb_valid_d   = 1'b0;
      wb_rd_wen_d  = 1'b0;
      wb_data_d    = wb_data_q;
      wb_rd_addr_d = wb_rd_addr_q;
    end
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      f3_q         <= '0;
      rd_addr_q    <= '0;
      rd_wen_q     <= 1'b0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      opb_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_addr_q <= '0;
      wb_rd_wen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      f3_q         <= f3_d;
      rd_addr_q    <= rd_addr_d;
      rd_wen_q     <= rd_wen_d;
      neg_q        <= neg_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_wen_q  <= wb_rd_wen_d;
    end
  end

  assign stall_req  = ~sys_rst & (((state_q == ST_IDLE) & start & ~flush) | (state_q == ST_CALC));
  assign busy       = (state_q != ST_IDLE);
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_rd_wen  = wb_rd_wen_q;

endmodule
